// File: rtl/mem4_reader_pkg.sv
// Shared types and helpers for the scratch-RAM stream reader.
package mem4_reader_pkg;

   // Widest word the extension helper handles.
   localparam int unsigned EXT_MAX_W = 64;
   localparam int unsigned EXT_IDX_W = $clog2(EXT_MAX_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_CAPT = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   // Keep the low data_w bits of raw; fill the rest with zeros or the sign bit.
   function automatic logic [EXT_MAX_W-1:0] extend_word(
      input logic [EXT_MAX_W-1:0] raw,
      input int unsigned          data_w,
      input logic                 sign_ext
   );
      logic [EXT_MAX_W-1:0] mask;
      logic [EXT_IDX_W-1:0] msb;
      mask = (EXT_MAX_W'(1) << data_w) - EXT_MAX_W'(1);
      msb  = EXT_IDX_W'(data_w - 1);
      extend_word = raw & mask;
      if (sign_ext && raw[msb]) begin
         extend_word = extend_word | ~mask;
      end
   endfunction

endpackage

// File: rtl/hs_out_reg.sv
// Valid/ready output stage: holds data and last until the consumer takes them.
module hs_out_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             last_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             last_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             last_q, last_d;

   // Load a new word, or retire the current one on handshake; data holds otherwise.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule

// File: rtl/mem4_stream_reader.sv
// Reads len words from a sync-read RAM starting at base (wrapping) and streams them out.
module mem4_stream_reader
   import mem4_reader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OUT_WIDTH  = 32,
   parameter int unsigned SIGN_EXT   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      remaining_q, remaining_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  mem_en_q, mem_en_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

   logic                  load_c;
   logic                  hs_c;
   logic                  last_word_c;
   logic [ADDR_WIDTH-1:0] addr_inc_c;
   logic [OUT_WIDTH-1:0]  ext_c;

   assign hs_c        = out_valid & out_ready;
   assign last_word_c = (remaining_q == CNT_W'(1));
   assign addr_inc_c  = addr_q + ADDR_WIDTH'(1);
   assign ext_c       = OUT_WIDTH'(extend_word(EXT_MAX_W'(mem_dout), DATA_WIDTH, SIGN_EXT != 0));

   // Next-state logic; RAM strobe and address are set on the edge entering READ.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      mem_en_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      load_c      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  addr_d      = base;
                  remaining_d = len;
                  mem_en_d    = 1'b1;
                  mem_addr_d  = base;
                  state_d     = ST_READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            state_d = ST_CAPT;
         end
         ST_CAPT: begin
            load_c  = 1'b1;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (hs_c) begin
               remaining_d = remaining_q - CNT_W'(1);
               addr_d      = addr_inc_c;
               if (last_word_c) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = addr_inc_c;
                  state_d    = ST_READ;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, counters and registered control outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mem_en_q    <= mem_en_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   // Output stage holding the captured word until handshake.
   hs_out_reg #(
      .WIDTH(OUT_WIDTH)
   ) u_out (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_c),
      .data_i  (ext_c),
      .last_i  (last_word_c),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .data_o  (out_data),
      .last_o  (out_last)
   );

   assign busy     = busy_q;
   assign done     = done_q;
   assign mem_en   = mem_en_q;
   assign mem_addr = mem_addr_q;

endmodule
